// File: rtl/clk_divider_prog.sv
// clk_divider_prog: programmable clock divider with toggle/pulse output and glitch-free divisor reload
module clk_divider_prog #(
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  input  logic             mode,
  output logic             div_ack,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] cur_div
);
  logic [WIDTH-1:0] count, active_div, pending_div;
  logic             pending_valid, active_mode, term, clk_next;
  assign term    = en && count == active_div;
  assign cur_div = active_div;
  // next output level: pulse mode follows the next tick, toggle mode flips on terminal, leaving pulse forces low
  always_comb clk_next = term ? (mode ? 1'b1 : (active_mode ? 1'b0 : ~clk_out))
                              : (active_mode ? 1'b0 : clk_out);
  // counter, divisor/mode reload on terminal cycles, load capture and strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      active_div    <= WIDTH'(DEFAULT_DIV);
      pending_div   <= '0;
      pending_valid <= 1'b0;
      active_mode   <= 1'b0;
      clk_out       <= 1'b0;
      tick          <= 1'b0;
      div_ack       <= 1'b0;
    end else begin
      div_ack <= div_load;
      tick    <= term;
      clk_out <= clk_next;
      if (en) count <= term ? '0 : count + WIDTH'(1);
      if (term) active_mode <= mode;
      if (term && pending_valid) active_div <= pending_div;
      if (div_load) begin
        pending_div   <= div_in;
        pending_valid <= 1'b1;
      end else if (term) begin
        pending_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_clk_divider_prog.sv
// tb_clk_divider_prog: scenario and randomized checks of clk_divider_prog against a behavioural model
module tb_clk_divider_prog;
  localparam int W = 8;
  localparam int DD = 3;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, div_load = 1'b0, mode = 1'b0;
  logic [W-1:0] div_in = '0;
  logic div_ack, clk_out, tick;
  logic [W-1:0] cur_div;
  int n_cmp = 0, n_err = 0;
  // behavioural model state
  int m_cnt;
  logic [W-1:0] m_div;
  logic [W-1:0] m_pq[$];
  logic m_mode, m_clk, m_tick, m_ack;

  clk_divider_prog #(.WIDTH(W), .DEFAULT_DIV(DD)) dut (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load), .mode(mode),
    .div_ack(div_ack), .clk_out(clk_out), .tick(tick), .cur_div(cur_div)
  );

  always #5 clk = ~clk;

  // one rising edge: the model consumes the same inputs as the DUT, outputs are sampled 1ns later
  task automatic step();
    bit term, old_mode;
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_div = DD; m_pq.delete(); m_mode = 0; m_clk = 0; m_tick = 0; m_ack = 0;
    end else begin
      term = en && (m_cnt == int'(m_div));
      old_mode = m_mode;
      m_ack = div_load;
      m_tick = term;
      if (term) begin
        if (m_pq.size() > 0) m_div = m_pq.pop_back();
        m_pq.delete();
        m_mode = mode;
      end
      if (div_load) begin
        m_pq.delete();
        m_pq.push_back(div_in);
      end
      if (m_mode) m_clk = m_tick;
      else if (term) m_clk = old_mode ? 1'b0 : ~m_clk;
      if (en) m_cnt = term ? 0 : m_cnt + 1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; en = 0; div_load = 0; mode = 0;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; div_load = 1; div_in = 8'd9;
    step(); step();
    n_cmp++;
    if ({clk_out, tick, div_ack, cur_div} !== {3'b000, 8'(DD)}) begin
      n_err++; $display("FAIL reset: got clk_out=%b tick=%b ack=%b cur_div=%0d, want 0 0 0 %0d", clk_out, tick, div_ack, cur_div, DD);
    end
    rst = 0; div_load = 0;
    step();
    n_cmp++;
    if (div_ack !== 1'b0 || cur_div !== 8'(DD)) begin
      n_err++; $display("FAIL reset_load_discard: got ack=%b cur_div=%0d, want 0 %0d", div_ack, cur_div, DD);
    end
  endtask

  task automatic test_toggle();
    do_reset();
    en = 1;
    for (int i = 1; i <= 20; i++) begin
      step();
      n_cmp++;
      if (clk_out !== ((i / 4) % 2 == 1) || tick !== (i % 4 == 0)) begin
        n_err++; $display("FAIL toggle cyc%0d: got clk_out=%b tick=%b, want %b %b", i, clk_out, tick, (i / 4) % 2 == 1, i % 4 == 0);
      end
    end
  endtask

  task automatic test_load();
    do_reset();
    en = 1;
    for (int i = 0; i < 20 && m_cnt != 1; i++) step();
    n_cmp++;
    if (m_cnt != 1) begin n_err++; $display("FAIL load_wait: count 1 not reached"); end
    div_load = 1; div_in = 8'd1;
    step();
    div_load = 0;
    n_cmp++;
    if (div_ack !== 1'b1 || cur_div !== 8'd3) begin
      n_err++; $display("FAIL load_ack: got ack=%b cur_div=%0d, want 1 3", div_ack, cur_div);
    end
    for (int i = 0; i < 14; i++) begin
      step();
      n_cmp++;
      if ({clk_out, tick, div_ack, cur_div} !== {m_clk, m_tick, m_ack, m_div}) begin
        n_err++; $display("FAIL load cyc%0d: got %b%b%b/%0d want %b%b%b/%0d", i, clk_out, tick, div_ack, cur_div, m_clk, m_tick, m_ack, m_div);
      end
    end
    n_cmp++;
    if (cur_div !== 8'd1) begin n_err++; $display("FAIL load_applied: got cur_div=%0d want 1", cur_div); end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    bit saw5 = 0;
    do_reset();
    en = 1;
    step();
    div_load = 1; div_in = 8'd5;
    step(); acks += div_ack;
    div_in = 8'd7;
    step(); acks += div_ack;
    div_load = 0;
    step(); acks += div_ack;
    for (int i = 0; i < 24; i++) begin
      step();
      saw5 |= (cur_div == 8'd5);
      n_cmp++;
      if ({clk_out, tick, div_ack, cur_div} !== {m_clk, m_tick, m_ack, m_div}) begin
        n_err++; $display("FAIL b2b cyc%0d: got %b%b%b/%0d want %b%b%b/%0d", i, clk_out, tick, div_ack, cur_div, m_clk, m_tick, m_ack, m_div);
      end
    end
    n_cmp++;
    if (acks != 2 || saw5 || cur_div !== 8'd7) begin
      n_err++; $display("FAIL b2b_summary: acks=%0d saw5=%0d cur_div=%0d, want 2 0 7", acks, saw5, cur_div);
    end
  endtask

  task automatic test_div0_pulse();
    do_reset();
    en = 1; mode = 1; div_load = 1; div_in = 8'd0;
    step();
    div_load = 0;
    for (int i = 0; i < 8; i++) step();
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (tick !== 1'b1 || clk_out !== 1'b1 || cur_div !== 8'd0) begin
        n_err++; $display("FAIL div0_high: got tick=%b clk_out=%b cur_div=%0d, want 1 1 0", tick, clk_out, cur_div);
      end
    end
    en = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (tick !== 1'b0 || clk_out !== 1'b0) begin
        n_err++; $display("FAIL div0_en_off: got tick=%b clk_out=%b, want 0 0", tick, clk_out);
      end
    end
    en = 1;
    step();
    n_cmp++;
    if (tick !== 1'b1 || clk_out !== 1'b1) begin
      n_err++; $display("FAIL div0_resume: got tick=%b clk_out=%b, want 1 1", tick, clk_out);
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    en = 1;
    for (int i = 0; i < 5; i++) step();
    mode = 1;
    step(); step();
    n_cmp++;
    if (clk_out !== 1'b1 || tick !== 1'b0) begin
      n_err++; $display("FAIL mode_hold: got clk_out=%b tick=%b, want 1 0", clk_out, tick);
    end
    for (int i = 1; i <= 12; i++) begin
      step();
      n_cmp++;
      if (clk_out !== (i % 4 == 1) || tick !== (i % 4 == 1)) begin
        n_err++; $display("FAIL mode_pulse cyc%0d: got clk_out=%b tick=%b, want %b", i, clk_out, tick, i % 4 == 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1;
    for (int i = 0; i < 20 && m_cnt != 2; i++) step();
    rst = 1; div_load = 1; div_in = 8'd9;
    step();
    rst = 0; div_load = 0;
    n_cmp++;
    if ({clk_out, tick, div_ack, cur_div} !== {3'b000, 8'(DD)}) begin
      n_err++; $display("FAIL reset_mid: got %b%b%b/%0d want 000/%0d", clk_out, tick, div_ack, cur_div, DD);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      n_cmp++;
      if (clk_out !== (i == 4) || div_ack !== 1'b0 || cur_div !== 8'(DD)) begin
        n_err++; $display("FAIL reset_restart cyc%0d: got clk_out=%b ack=%b cur_div=%0d", i, clk_out, div_ack, cur_div);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 9) != 0);
      div_load = ($urandom_range(0, 7) == 0);
      div_in = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      step();
      n_cmp++;
      if ({clk_out, tick, div_ack, cur_div} !== {m_clk, m_tick, m_ack, m_div}) begin
        n_err++; $display("FAIL random cyc%0d: got %b%b%b/%0d want %b%b%b/%0d", i, clk_out, tick, div_ack, cur_div, m_clk, m_tick, m_ack, m_div);
      end
    end
    rst = 0; div_load = 0;
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_load();
    test_back_to_back();
    test_div0_pulse();
    test_mode_switch();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/clk_divider_prog.md
CLK_DIVIDER_PROG -- requirements
Module: clk_divider_prog

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the width of the divisor and counter.
REQ-002 Parameter DEFAULT_DIV, default 500, SHALL be the divisor loaded on reset; it must be less than 2^WIDTH.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous and active-high.
REQ-005 en  input  1  SHALL be the count enable.
REQ-006 div_in  input  WIDTH  SHALL be the new divisor value, sampled when div_load=1.
REQ-007 div_load  input  1  SHALL be the divisor load request, one cycle per request.
REQ-008 mode  input  1  SHALL select the output mode: 0=toggle (50% duty), 1=pulse.
REQ-009 div_ack  output  1  SHALL be a one-cycle acknowledge of a captured load.
REQ-010 clk_out  output  1  SHALL be the divided output, registered.
REQ-011 tick  output  1  SHALL be a one-cycle, registered period-boundary strobe.
REQ-012 cur_div  output  WIDTH  SHALL show the divisor currently in effect.

Function
REQ-013 State SHALL consist of: count[WIDTH], active_div[WIDTH], pending_div[WIDTH], pending_valid, active_mode, clk_out, tick, div_ack.
REQ-014 The terminal cycle SHALL be any cycle with en=1 and count==active_div.
REQ-015 On a terminal cycle, the block SHALL set count<=0; otherwise, while en=1, it SHALL set count<=count+1.
REQ-016 The half-period SHALL equal active_div+1 enabled cycles; in toggle mode the output period SHALL equal 2*(active_div+1) cycles.
REQ-017 tick SHALL be 1 in the cycle after each terminal cycle and 0 in all other cycles.
REQ-018 With active_mode=0, clk_out SHALL invert on each terminal cycle.
REQ-019 With active_mode=1, clk_out SHALL equal the next-state value of tick, so it is high for exactly 1 of every active_div+1 enabled cycles.
REQ-020 When div_load=1, the block SHALL set pending_div<=div_in and pending_valid<=1, and SHALL assert div_ack<=1 for one cycle; this SHALL occur regardless of en.
REQ-021 Back-to-back loads SHALL overwrite the pending value (last value wins), and each load SHALL be acked.
REQ-022 On a terminal cycle with pending_valid=1, the block SHALL set active_div<=pending_div and clear pending_valid; the new divisor SHALL govern the next half-period.
REQ-023 If a load coincides with a terminal cycle, the older pending value (if any) SHALL be applied, the new value SHALL become pending, and pending_valid SHALL remain 1.
REQ-024 If a load coincides with a terminal cycle and nothing was pending, the new value SHALL become pending and SHALL NOT be applied until the following terminal cycle.
REQ-025 The block SHALL sample mode into active_mode only on terminal cycles, so a mode change never truncates a period.
REQ-026 On the terminal cycle where active_mode switches to 0, clk_out SHALL be forced to 0.
REQ-027 With divisor 0, every enabled cycle SHALL be terminal: toggle mode SHALL produce clk/2, and pulse mode SHALL hold tick high continuously.
REQ-028 While en=0, count, clk_out (toggle mode) and active_div SHALL hold, and tick SHALL be 0; in pulse mode clk_out SHALL be 0.
REQ-029 Loads SHALL still be captured while en=0.
REQ-030 cur_div SHALL equal active_div combinationally.
REQ-031 Counter arithmetic SHALL be modulo 2^WIDTH; the equality compare guarantees that count never exceeds active_div.

Reset
REQ-032 While rst=1 at a clock edge, the block SHALL set: count=0, active_div=DEFAULT_DIV, pending_div=0, pending_valid=0, active_mode=0, clk_out=0, tick=0, div_ack=0.
REQ-033 rst SHALL take priority over en and div_load.
REQ-034 A load presented in the same cycle as rst SHALL be discarded and SHALL NOT be acked.
REQ-035 Reset mid-period SHALL abandon the period; counting SHALL restart from 0 on the first edge after release.

Verification
REQ-036 Scenario 1: DEFAULT_DIV=3, mode=0, en=1 after reset -> clk_out rises after the 4th edge and then toggles every 4 cycles (period 8); tick pulses every 4 cycles.
REQ-037 Scenario 2: div=3 running, load div_in=1 at count=1 -> div_ack the next cycle; cur_div stays 3 until the terminal cycle, then 1; the half-period becomes 2.
REQ-038 Scenario 3: loads of 5 then 7 on consecutive cycles before a terminal cycle -> two acks; 7 is applied at the terminal cycle; 5 never appears on cur_div.
REQ-039 Scenario 4: div=0, mode=1 -> tick=1 and clk_out=1 every cycle; then en=0 -> both drop to 0 the next cycle and count holds.
REQ-040 Scenario 5: div=3, mode switched 0->1 mid-half-period -> no change until the terminal cycle; then clk_out is a 1-cycle pulse every 4 cycles.
REQ-041 Scenario 6: rst asserted at count=2 together with div_load=1 -> all outputs 0, cur_div=DEFAULT_DIV, no ack; counting restarts from 0.
